hwpe_ctrl_regfile_bridge: RTL and testbench

Peripheral-bus target that front-ends the HWPE control register file. It accepts PULP-style periph requests (req/gnt, active-low write enable, byte enables, transaction ID) from the cluster interconnect and converts them into the register file's single-cycle write port and one-cycle-latency read port. It returns read data and write acknowledges with the originating ID, and holds off writes to protected (job) registers while the engine holds `lock_i`, with a bounded-wait timeout that reports an error.

---
 rtl/hwpe_ctrl_regfile_bridge_pkg.sv | 18 +
 rtl/hwpe_ctrl_regfile_bridge.sv | 150 +++++++++++++++
 tb/tb_hwpe_ctrl_regfile_bridge.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hwpe_ctrl_regfile_bridge_pkg.sv
// Types shared by the HWPE control register-file bridge and its neighbours.
package hwpe_ctrl_package;

   localparam int MaxIdWidth = 32;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      STALL = 1'b1
   } regfile_bridge_state_t;

   typedef struct packed {
      logic                  valid;
      logic [MaxIdWidth-1:0] id;
      logic                  err;
      logic                  is_read;
   } regfile_resp_t;

endpackage

// File: rtl/hwpe_ctrl_regfile_bridge.sv
// Periph-bus target in front of the HWPE control register file: grant decision,
// lock stall with timeout, and a one-cycle registered response.
//
// state | meaning
// IDLE  | accept any request; protected write under lock moves to STALL
// STALL | hold a protected write until lock drops, req drops or timeout
module hwpe_ctrl_regfile_bridge
   import hwpe_ctrl_package::*;
#(
   parameter int AddrWidth     = 5,
   parameter int DataWidth     = 32,
   parameter int IdWidth       = 8,
   parameter int ProtBase      = 8,
   parameter int TimeoutCycles = 64
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   clear_i,
   input  logic                   lock_i,
   input  logic                   req_i,
   output logic                   gnt_o,
   input  logic [31:0]            add_i,
   input  logic                   wen_i,
   input  logic [DataWidth/8-1:0] be_i,
   input  logic [DataWidth-1:0]   data_i,
   input  logic [IdWidth-1:0]     id_i,
   output logic                   r_valid_o,
   output logic [DataWidth-1:0]   r_data_o,
   output logic [IdWidth-1:0]     r_id_o,
   output logic                   r_err_o,
   output logic                   ReadEnable_o,
   output logic [AddrWidth-1:0]   ReadAddr_o,
   input  logic [DataWidth-1:0]   ReadData_i,
   output logic                   WriteEnable_o,
   output logic [AddrWidth-1:0]   WriteAddr_o,
   output logic [DataWidth-1:0]   WriteData_o,
   output logic [DataWidth/8-1:0] WriteBE_o
);

   localparam int                  CntWidth = $clog2(TimeoutCycles + 1);
   localparam logic [CntWidth-1:0] CntMax   = CntWidth'(TimeoutCycles);
   localparam logic [31:0]         ProtIdx  = 32'(ProtBase);

   regfile_bridge_state_t state_q, state_d;
   logic [CntWidth-1:0]   cnt_q, cnt_d;
   regfile_resp_t         resp_q, resp_d;

   logic [AddrWidth-1:0] idx;
   logic                 out_of_range;
   logic                 is_read;
   logic                 blocked;
   logic                 grant;
   logic                 err;
   logic                 strobe;
   logic                 addr_lsb_unused;
   logic                 resp_id_unused;

   assign idx          = add_i[AddrWidth+1:2];
   assign out_of_range = |add_i[31:AddrWidth+2];
   assign is_read      = wen_i;
   assign blocked      = !is_read && (32'(idx) >= ProtIdx) && lock_i && !out_of_range;

   assign addr_lsb_unused = ^add_i[1:0];
   assign resp_id_unused  = |(resp_q.id >> IdWidth);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      grant   = 1'b0;
      err     = 1'b0;
      if (clear_i) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_i) begin
                  if (blocked) begin
                     state_d = STALL;
                     cnt_d   = CntWidth'(1);
                  end else begin
                     grant = 1'b1;
                     err   = out_of_range;
                  end
               end
            end
            STALL: begin
               if (!req_i) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (!blocked) begin
                  grant   = 1'b1;
                  err     = out_of_range;
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (cnt_q >= CntMax) begin
                  grant   = 1'b1;
                  err     = 1'b1;
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  // cnt_q < CntMax here, so the increment can never wrap
                  cnt_d = cnt_q + CntWidth'(1);
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign strobe = grant && !err;
   assign gnt_o  = grant;

   assign ReadEnable_o  = strobe && is_read;
   assign ReadAddr_o    = ReadEnable_o ? idx : '0;
   assign WriteEnable_o = strobe && !is_read;
   assign WriteAddr_o   = WriteEnable_o ? idx : '0;
   assign WriteData_o   = WriteEnable_o ? data_i : '0;
   assign WriteBE_o     = WriteEnable_o ? be_i : '0;

   always_comb begin
      resp_d         = '0;
      resp_d.valid   = grant;
      resp_d.id      = grant ? MaxIdWidth'(id_i) : '0;
      resp_d.err     = grant && err;
      resp_d.is_read = grant && is_read && !err;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         resp_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         resp_q  <= resp_d;
      end
   end

   // Read data arrives from the regfile one cycle after the strobe, aligned with resp_q
   assign r_valid_o = resp_q.valid;
   assign r_id_o    = resp_q.id[IdWidth-1:0];
   assign r_err_o   = resp_q.err;
   assign r_data_o  = (resp_q.valid && resp_q.is_read) ? ReadData_i : '0;

endmodule

// File: tb/tb_hwpe_ctrl_regfile_bridge.sv
// Scoreboard bench for hwpe_ctrl_regfile_bridge: directed scenarios plus random traffic
// against a word-array reference model and a behavioural register file.
module tb_hwpe_ctrl_regfile_bridge;

   localparam int TIMEOUT  = 64;
   localparam int PROT     = 8;
   localparam int NWORDS   = 32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear;
   logic        lock;
   logic        req;
   logic        gnt;
   logic [31:0] add;
   logic        wen;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic [7:0]  id;
   logic        r_valid;
   logic [31:0] r_data;
   logic [7:0]  r_id;
   logic        r_err;
   logic        rf_re;
   logic [4:0]  rf_raddr;
   logic [31:0] rf_rdata;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [3:0]  rf_wbe;

   hwpe_ctrl_regfile_bridge #(
      .AddrWidth(5), .DataWidth(32), .IdWidth(8), .ProtBase(PROT), .TimeoutCycles(TIMEOUT)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .lock_i(lock),
      .req_i(req), .gnt_o(gnt), .add_i(add), .wen_i(wen), .be_i(be), .data_i(wdata), .id_i(id),
      .r_valid_o(r_valid), .r_data_o(r_data), .r_id_o(r_id), .r_err_o(r_err),
      .ReadEnable_o(rf_re), .ReadAddr_o(rf_raddr), .ReadData_i(rf_rdata),
      .WriteEnable_o(rf_we), .WriteAddr_o(rf_waddr), .WriteData_o(rf_wdata), .WriteBE_o(rf_wbe)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural register file driven by the DUT's strobes
   logic [31:0] rf [NWORDS] = '{default: 32'h0};
   always @(posedge clk) begin
      if (rf_we)
         for (int b = 0; b < 4; b++)
            if (rf_wbe[b]) rf[rf_waddr][8*b +: 8] <= rf_wdata[8*b +: 8];
      if (rf_re) rf_rdata <= rf[rf_raddr];
   end

   logic [31:0] ref_mem [NWORDS] = '{default: 32'h0};

   typedef struct {
      int          due;
      logic [7:0]  id;
      logic        err;
      logic [31:0] data;
   } exp_t;
   exp_t exp_q [$];

   int vectors = 0;
   int fails   = 0;
   bit mon_en  = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   exp_t mon_e;
   bit   mon_due;
   always @(negedge clk) begin
      if (mon_en) begin
         mon_due = (exp_q.size() > 0) && (exp_q[0].due == cyc);
         chk("r_valid", 64'(r_valid), 64'(mon_due));
         if (mon_due) begin
            mon_e = exp_q.pop_front();
            if (r_valid) begin
               chk("r_id", 64'(r_id), 64'(mon_e.id));
               chk("r_err", 64'(r_err), 64'(mon_e.err));
               chk("r_data", 64'(r_data), 64'(mon_e.data));
            end
         end
      end
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      req   = 1'b0;
      wen   = 1'b1;
      add   = '0;
      wdata = '0;
      be    = '0;
      id    = '0;
   endtask

   task automatic apply_write(input int ix, input logic [31:0] d, input logic [3:0] b);
      for (int k = 0; k < 4; k++)
         if (b[k]) ref_mem[ix][8*k +: 8] = d[8*k +: 8];
   endtask

   // One-cycle transaction that must be granted immediately
   task automatic single(input bit rd, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, input logic [7:0] i, input bit lk);
      bit   oor;
      int   ix;
      exp_t e;
      req = 1'b1; wen = rd; add = a; wdata = d; be = b; id = i; lock = lk;
      oor = (a[31:7] != 0);
      ix  = int'(a[6:2]);
      @(negedge clk);
      chk("gnt", 64'(gnt), 64'(1));
      chk("read_en", 64'(rf_re), 64'(rd && !oor));
      chk("write_en", 64'(rf_we), 64'(!rd && !oor));
      if (rd && !oor) chk("read_addr", 64'(rf_raddr), 64'(ix));
      if (!rd && !oor) begin
         chk("write_addr", 64'(rf_waddr), 64'(ix));
         chk("write_data", 64'(rf_wdata), 64'(d));
         chk("write_be", 64'(rf_wbe), 64'(b));
      end
      e.due  = cyc + 1;
      e.id   = i;
      e.err  = oor;
      e.data = (rd && !oor) ? ref_mem[ix] : 32'h0;
      exp_q.push_back(e);
      if (!rd && !oor) apply_write(ix, d, b);
      next();
   endtask

   // Protected write under lock; release_at = 0 means the lock is never released
   task automatic locked_write(input int ix, input logic [31:0] d, input logic [3:0] b,
                               input logic [7:0] i, input int release_at);
      bit   exp_g;
      bit   tmo;
      exp_t e;
      req = 1'b1; wen = 1'b0; add = {25'h0, 5'(ix), 2'(ix)}; wdata = d; be = b; id = i;
      lock = 1'b1;
      tmo  = (release_at == 0);
      @(negedge clk);
      chk("stall_entry_gnt", 64'(gnt), 64'(0));
      chk("stall_entry_we", 64'(rf_we), 64'(0));
      next();
      for (int j = 1; j <= TIMEOUT; j++) begin
         if (release_at == j) lock = 1'b0;
         @(negedge clk);
         exp_g = (release_at == j) || (tmo && j == TIMEOUT);
         chk("stall_gnt", 64'(gnt), 64'(exp_g));
         chk("stall_we", 64'(rf_we), 64'(exp_g && !tmo));
         if (exp_g) begin
            if (!tmo) begin
               chk("stall_waddr", 64'(rf_waddr), 64'(ix));
               chk("stall_wdata", 64'(rf_wdata), 64'(d));
               apply_write(ix, d, b);
            end
            e.due  = cyc + 1;
            e.id   = i;
            e.err  = tmo;
            e.data = 32'h0;
            exp_q.push_back(e);
         end
         next();
         if (exp_g) break;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      clear = 1'b0;
      lock  = 1'b0;
      set_idle();
      repeat (2) @(negedge clk);
      chk("rst_gnt", 64'(gnt), 64'(0));
      chk("rst_r_valid", 64'(r_valid), 64'(0));
      chk("rst_r_data", 64'(r_data), 64'(0));
      chk("rst_r_id", 64'(r_id), 64'(0));
      chk("rst_r_err", 64'(r_err), 64'(0));
      chk("rst_strobes", 64'({rf_re, rf_we, rf_raddr, rf_waddr, rf_wbe}), 64'(0));
      chk("rst_wdata", 64'(rf_wdata), 64'(0));
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;
      next();

      // write then read of the same word, back to back
      single(1'b0, 32'h0000_000C, 32'hDEAD_BEEF, 4'hF, 8'h11, 1'b0);
      single(1'b1, 32'h0000_000C, 32'h0, 4'h0, 8'h12, 1'b0);
      set_idle();
      next();

      // lock released after 5 stalled cycles
      locked_write(10, 32'hCAFE_0001, 4'hF, 8'h21, 5);
      set_idle();
      next();
      single(1'b1, 32'h0000_0028, 32'h0, 4'h0, 8'h22, 1'b0);

      // lock never released -> timeout error, no write
      locked_write(10, 32'h5555_AAAA, 4'hF, 8'h31, 0);
      set_idle();
      lock = 1'b0;
      next();
      single(1'b1, 32'h0000_0028, 32'h0, 4'h0, 8'h32, 1'b0);

      // out-of-range read
      single(1'b1, 32'h0000_1000, 32'h0, 4'h0, 8'h41, 1'b0);

      // clear during stall: no grant, no response
      req = 1'b1; wen = 1'b0; add = 32'h0000_0030; wdata = 32'h1234_5678; be = 4'hF; id = 8'h51;
      lock = 1'b1;
      repeat (3) next();
      clear = 1'b1;
      @(negedge clk);
      chk("clear_stall_gnt", 64'(gnt), 64'(0));
      next();
      clear = 1'b0;
      set_idle();
      lock = 1'b0;
      repeat (2) next();

      // clear in the grant cycle of a read
      req = 1'b1; wen = 1'b1; add = 32'h0000_000C; id = 8'h61; clear = 1'b1;
      @(negedge clk);
      chk("clear_read_gnt", 64'(gnt), 64'(0));
      chk("clear_read_re", 64'(rf_re), 64'(0));
      next();
      clear = 1'b0;
      set_idle();
      repeat (2) next();

      // unprotected write under lock, then 16 back-to-back reads
      single(1'b0, 32'h0000_0008, 32'h0BAD_F00D, 4'h5, 8'h70, 1'b1);
      for (int k = 0; k < 16; k++)
         single(1'b1, 32'(k * 4), 32'h0, 4'h0, 8'(8'h80 + k), 1'b1);
      set_idle();
      lock = 1'b0;
      next();

      // random traffic
      for (int n = 0; n < 300; n++) begin
         bit          rd, lk, oor;
         int          ix;
         logic [31:0] a;
         rd  = ($urandom_range(0, 1) == 1);
         lk  = ($urandom_range(0, 2) == 0);
         oor = ($urandom_range(0, 9) == 0);
         ix  = int'($urandom_range(0, NWORDS - 1));
         if (oor) a = $urandom | 32'h0000_0080;
         else     a = {25'h0, 5'(ix), 2'($urandom_range(0, 3))};
         if (!rd && !oor && lk && ix >= PROT)
            locked_write(ix, $urandom, 4'($urandom), 8'($urandom),
                         ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 20)));
         else
            single(rd, a, $urandom, 4'($urandom), 8'($urandom), lk);
         if ($urandom_range(0, 3) == 0) begin
            set_idle();
            next();
         end
      end

      set_idle();
      lock = 1'b0;
      repeat (3) next();
      chk("queue_drained", 64'(exp_q.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
